// File: rtl/pll_lock_seq_pkg.sv
// Shared types for the rPLL lock sequencer: FSM states, divider payload and counter sizing.
package pll_lock_seq_pkg;

    localparam int unsigned SEL_W = 6;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } div_cfg_t;

    // One counter serves every timed state, so it must hold the largest terminal value.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_seq_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clkin domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_seq.sv
// rPLL reset/lock sequencer with timeout, bounded retry and runtime divider reload.
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int unsigned      RST_CYCLES          = 16,
    parameter int unsigned      LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned      LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned      MAX_RETRIES         = 3,
    parameter logic [SEL_W-1:0] DEF_IDSEL           = 6'd0,
    parameter logic [SEL_W-1:0] DEF_FBDSEL          = 6'd0,
    parameter logic [SEL_W-1:0] DEF_ODSEL           = 6'd0
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    input  logic             pll_lock,
    output logic             out_rst,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       retry_cnt
);

    localparam int unsigned      CNT_W        = cnt_width(RST_CYCLES, LOCK_STABLE_CYCLES,
                                                          LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);
    localparam div_cfg_t         DEF_DIV      = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL};

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry_nxt;
    div_cfg_t         div_q, div_nxt, cfg_in;
    logic             lock_s;
    logic             cfg_accept;
    logic             pll_reset_nxt, out_rst_nxt, locked_nxt, fault_nxt, cfg_ready_nxt;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign cfg_in     = {cfg_idsel, cfg_fbdsel, cfg_odsel};
    assign cfg_accept = cfg_valid && cfg_ready;

    // Next state, counter, retry and divider selection; outputs decoded from the state entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        retry_nxt = retry_cnt;
        div_nxt   = div_q;

        unique case (state)
            ST_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = ST_RESET_PLL;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = 2'd0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                // A config offered alongside lock loss still wins; both lead to a single reset.
                if (cfg_accept) begin
                    div_nxt   = cfg_in;
                    state_nxt = ST_RESET_PLL;
                end else if (!lock_s) begin
                    state_nxt = ST_RESET_PLL;
                end
            end
            ST_FAULT: begin
                cnt_nxt = '0;
                if (cfg_accept) begin
                    div_nxt   = cfg_in;
                    retry_nxt = 2'd0;
                    state_nxt = ST_RESET_PLL;
                end
            end
            default: begin
                state_nxt = ST_RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase

        pll_reset_nxt = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
        out_rst_nxt   = (state_nxt != ST_RUN);
        locked_nxt    = (state_nxt == ST_RUN);
        fault_nxt     = (state_nxt == ST_FAULT);
        cfg_ready_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_FAULT);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= ST_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= 2'd0;
            div_q     <= DEF_DIV;
            pll_reset <= 1'b1;
            out_rst   <= 1'b1;
            locked    <= 1'b0;
            fault     <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            div_q     <= div_nxt;
            pll_reset <= pll_reset_nxt;
            out_rst   <= out_rst_nxt;
            locked    <= locked_nxt;
            fault     <= fault_nxt;
            cfg_ready <= cfg_ready_nxt;
        end
    end

    assign pll_idsel  = div_q.idsel;
    assign pll_fbdsel = div_q.fbdsel;
    assign pll_odsel  = div_q.odsel;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed/randomized bench for pll_lock_seq with a lock-producing PLL model and timing arithmetic.
`timescale 1ns/1ps
module tb_pll_lock_seq;

    localparam int unsigned RSTC    = 4;
    localparam int unsigned STBC    = 8;
    localparam int unsigned TOC     = 32;
    localparam int unsigned MAXR    = 2;
    localparam int unsigned LOCK_DLY = 3;
    // pll_reset falls -> lock rises LOCK_DLY later -> 2 sync flops -> 1 WAIT_LOCK edge -> STBC stable.
    localparam int unsigned RUN_LAT = 1 + LOCK_DLY + 2 + STBC;
    localparam int unsigned ATTEMPT = RSTC + TOC;
    localparam logic [5:0]  DEF_I = 6'd1;
    localparam logic [5:0]  DEF_F = 6'd2;
    localparam logic [5:0]  DEF_O = 6'd3;

    logic       clkin = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_lock;
    logic       out_rst, locked, fault;
    logic [1:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int since = 0;
    bit lock_en   = 1'b1;
    bit lock_kill = 1'b0;

    pll_lock_seq #(
        .RST_CYCLES          (RSTC),
        .LOCK_STABLE_CYCLES  (STBC),
        .LOCK_TIMEOUT_CYCLES (TOC),
        .MAX_RETRIES         (MAXR),
        .DEF_IDSEL           (DEF_I),
        .DEF_FBDSEL          (DEF_F),
        .DEF_ODSEL           (DEF_O)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .pll_lock   (pll_lock),
        .out_rst    (out_rst),
        .locked     (locked),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    always #5 clkin = ~clkin;

    // PLL model: lock rises LOCK_DLY edges after RESET is released, unless disabled or killed.
    initial begin
        pll_lock = 1'b0;
        forever begin
            @(posedge clkin);
            #2;
            if (pll_reset !== 1'b0) since = 0;
            else since++;
            pll_lock = lock_en && !lock_kill && (pll_reset === 1'b0) && (since >= LOCK_DLY + 1);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_codes(input string tag, input logic [5:0] i, input logic [5:0] f,
                             input logic [5:0] o);
        chk(tag, 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({i, f, o}));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pll_reset"}, 32'(pll_reset), 32'd1);
        chk({tag, " out_rst"},   32'(out_rst),   32'd1);
        chk({tag, " locked"},    32'(locked),    32'd0);
        chk({tag, " fault"},     32'(fault),     32'd0);
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, " retry"},     32'(retry_cnt), 32'd0);
        chk_codes({tag, " codes"}, DEF_I, DEF_F, DEF_O);
    endtask

    // From a freshly entered RESET_PLL: measure pulse width and distance to RUN, optional lock glitch.
    task automatic run_seq(input string tag, input int glitch_at, input int exp_run);
        int hi;
        int n;
        hi = 0;
        while (pll_reset === 1'b1 && hi < 64) begin
            hi++;
            step();
        end
        chk({tag, " reset_width"}, 32'(hi), 32'(RSTC));
        n = 0;
        while (locked !== 1'b1 && n < 400) begin
            if (glitch_at >= 0 && n == glitch_at)     lock_kill = 1'b1;
            if (glitch_at >= 0 && n == glitch_at + 1) lock_kill = 1'b0;
            if (glitch_at >= 0 && n == glitch_at + 5)
                chk({tag, " retry_after_glitch"}, 32'(retry_cnt), 32'd0);
            step();
            n++;
        end
        lock_kill = 1'b0;
        chk({tag, " run_latency"}, 32'(n), 32'(exp_run));
        chk({tag, " out_rst"},     32'(out_rst),   32'd0);
        chk({tag, " retry"},       32'(retry_cnt), 32'd0);
        chk({tag, " cfg_ready"},   32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int n;
        int c;
        logic [5:0] ri, rf, ro;

        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_idsel  = '0;
        cfg_fbdsel = '0;
        cfg_odsel  = '0;

        // Cold start
        repeat (5) step();
        chk_reset_vals("rst");
        rst = 1'b0;
        run_seq("cold", -1, int'(RUN_LAT));
        chk_codes("cold codes", DEF_I, DEF_F, DEF_O);

        // Lock loss in RUN at a random point
        repeat ($urandom_range(0, 5)) step();
        lock_kill = 1'b1;
        step();
        step();
        chk("loss out_rst_N+1", 32'(out_rst), 32'd0);
        step();
        chk("loss out_rst_N+2",   32'(out_rst),   32'd1);
        chk("loss pll_reset_N+2", 32'(pll_reset), 32'd1);
        chk("loss locked_N+2",    32'(locked),    32'd0);
        lock_kill = 1'b0;
        run_seq("relock", -1, int'(RUN_LAT));

        // Glitch in STABLE at cnt=5, then at a random stable count
        for (int g = 0; g < 2; g++) begin
            c = (g == 0) ? 5 : int'($urandom_range(0, STBC - 2));
            lock_kill = 1'b1;
            step();
            lock_kill = 1'b0;
            step();
            step();
            chk("glitch restart pll_reset", 32'(pll_reset), 32'd1);
            run_seq(g == 0 ? "glitch5" : "glitch_rand", c + 4, c + 16);
        end

        // PLL never locks: retries exhausted, then FAULT
        lock_en = 1'b0;
        n = 0;
        while (pll_reset !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("nolock enter", 32'(n), 32'd3);
        repeat (ATTEMPT - 1) step();
        chk("nolock retry0", 32'(retry_cnt), 32'd0);
        step();
        chk("nolock retry1",    32'(retry_cnt), 32'd1);
        chk("nolock pll_reset", 32'(pll_reset), 32'd1);
        repeat (ATTEMPT) step();
        chk("nolock retry2", 32'(retry_cnt), 32'd2);
        n = 0;
        while (fault !== 1'b1 && n < int'(ATTEMPT) + 20) begin
            step();
            n++;
        end
        chk("fault time",      32'(n + 2 * int'(ATTEMPT)), 32'(3 * ATTEMPT));
        chk("fault pll_reset", 32'(pll_reset), 32'd1);
        chk("fault out_rst",   32'(out_rst),   32'd1);
        chk("fault cfg_ready", 32'(cfg_ready), 32'd1);
        repeat ($urandom_range(1, 10)) step();
        chk("fault stays", 32'(fault), 32'd1);
        chk("fault stays pll_reset", 32'(pll_reset), 32'd1);

        // Config in FAULT restarts the sequence
        lock_en    = 1'b1;
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'd1;
        cfg_fbdsel = 6'd4;
        cfg_odsel  = 6'd4;
        step();
        cfg_valid = 1'b0;
        chk("fcfg fault",     32'(fault),     32'd0);
        chk("fcfg pll_reset", 32'(pll_reset), 32'd1);
        chk("fcfg cfg_ready", 32'(cfg_ready), 32'd0);
        chk("fcfg retry",     32'(retry_cnt), 32'd0);
        chk_codes("fcfg codes", 6'd1, 6'd4, 6'd4);
        run_seq("after_fault", -1, int'(RUN_LAT));

        // Config in RUN; a held request during the sequence must not be taken
        repeat ($urandom_range(0, 3)) step();
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'd2;
        cfg_fbdsel = 6'd9;
        cfg_odsel  = 6'd3;
        step();
        chk("rcfg cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rcfg locked",    32'(locked),    32'd0);
        chk("rcfg out_rst",   32'(out_rst),   32'd1);
        chk("rcfg pll_reset", 32'(pll_reset), 32'd1);
        chk_codes("rcfg codes", 6'd2, 6'd9, 6'd3);
        cfg_idsel  = 6'($urandom_range(10, 63));
        cfg_fbdsel = 6'($urandom_range(0, 63));
        cfg_odsel  = 6'($urandom_range(0, 63));
        run_seq("cfg_run", -1, int'(RUN_LAT));
        cfg_valid = 1'b0;
        chk_codes("rcfg held ignored", 6'd2, 6'd9, 6'd3);
        step();
        step();
        chk("rcfg still run", 32'(locked), 32'd1);
        chk_codes("rcfg still codes", 6'd2, 6'd9, 6'd3);

        // Lock loss and config in the same cycle
        repeat ($urandom_range(0, 4)) step();
        ri = 6'($urandom_range(0, 63));
        rf = 6'($urandom_range(0, 63));
        ro = 6'($urandom_range(0, 63));
        lock_kill = 1'b1;
        step();
        step();
        chk("both pre locked", 32'(locked), 32'd1);
        cfg_valid  = 1'b1;
        cfg_idsel  = ri;
        cfg_fbdsel = rf;
        cfg_odsel  = ro;
        step();
        cfg_valid = 1'b0;
        lock_kill = 1'b0;
        chk("both pll_reset", 32'(pll_reset), 32'd1);
        chk_codes("both codes", ri, rf, ro);
        run_seq("loss_cfg", -1, int'(RUN_LAT));

        // rst while in STABLE
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'($urandom_range(4, 63));
        cfg_fbdsel = 6'($urandom_range(0, 63));
        cfg_odsel  = 6'($urandom_range(0, 63));
        step();
        cfg_valid = 1'b0;
        repeat (RSTC + STBC) step();
        chk("stable pre-rst locked", 32'(locked), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        run_seq("post_rst", -1, int'(RUN_LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
